// File: rtl/multi_cam_misalign_meter.sv
// Per-frame master/slave end_adc misalignment meter with one measurement FSM per slave channel.
// Define MISALIGN_AVG_EN to report a running average per channel instead of the latest raw result.

module multi_cam_misalign_chan #(
    parameter int CNT_W    = 16,
    parameter int SHIFT    = 1,
    parameter int TIMEOUT  = 1023
`ifdef MISALIGN_AVG_EN
    , parameter int AVG_LOG2 = 2
`endif
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             m_r_i,
    input  logic             s_f_i,
    input  logic             restart_i,
    output logic             done_o,
    output logic             err_o,
    output logic [CNT_W-1:0] res_o
);
    typedef enum logic [1:0] {IDLE, WAIT_SLAVE, WAIT_MASTER, DONE} state_t;

    localparam logic [CNT_W-1:0] TO     = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TO_MAG = TO >> SHIFT;

    state_t           st_q, st_d, st_cur;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, mag, res_new, res_q, res_d;
    logic             err_q, err_d, close, neg, tmo, closing_edge;
`ifdef MISALIGN_AVG_EN
    logic                    first_q, first_d;
    logic signed [CNT_W:0]   diff, step;
`endif

    always_comb begin
        // A restart makes this cycle behave as IDLE so the triggering edge is not lost
        st_cur       = restart_i ? IDLE : st_q;
        cnt_inc      = (cnt_q == TO) ? cnt_q : cnt_q + 1'b1;
        st_d         = st_cur;
        cnt_d        = cnt_q;
        err_d        = restart_i ? 1'b0 : err_q;
        close        = 1'b0;
        neg          = 1'b0;
        tmo          = 1'b0;
        mag          = '0;
        closing_edge = 1'b0;
        unique case (st_cur)
            IDLE: begin
                if (m_r_i && s_f_i) begin
                    st_d  = DONE;
                    close = 1'b1;
                end else if (m_r_i) begin
                    st_d  = WAIT_SLAVE;
                    cnt_d = '0;
                end else if (s_f_i) begin
                    st_d  = WAIT_MASTER;
                    cnt_d = '0;
                end
            end
            WAIT_SLAVE, WAIT_MASTER: begin
                cnt_d        = cnt_inc;
                neg          = (st_cur == WAIT_MASTER);
                closing_edge = neg ? m_r_i : s_f_i;
                if (closing_edge) begin
                    st_d  = DONE;
                    close = 1'b1;
                    mag   = cnt_inc >> SHIFT;
                end else if (cnt_inc == TO) begin
                    st_d  = DONE;
                    close = 1'b1;
                    tmo   = 1'b1;
                    mag   = TO_MAG;
                end
            end
            default: ;
        endcase
        res_new = neg ? ('0 - mag) : mag;
        if (close) err_d = tmo;
`ifdef MISALIGN_AVG_EN
        diff    = $signed({res_new[CNT_W-1], res_new}) - $signed({res_q[CNT_W-1], res_q});
        step    = diff >>> AVG_LOG2;
        res_d   = res_q;
        first_d = first_q;
        if (close && !tmo) begin
            first_d = 1'b0;
            res_d   = first_q ? res_new : res_q + step[CNT_W-1:0];
        end
`else
        res_d = close ? res_new : res_q;
`endif
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            st_q    <= IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
`ifdef MISALIGN_AVG_EN
            first_q <= 1'b1;
`endif
        end else begin
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            err_q   <= err_d;
`ifdef MISALIGN_AVG_EN
            first_q <= first_d;
`endif
        end
    end

    assign done_o = (st_q == DONE);
    assign err_o  = err_q;
    assign res_o  = res_q;
endmodule

module multi_cam_misalign_meter #(
    parameter int NUM_SLAVES = 3,
    parameter int CNT_W      = 16,
    parameter int SHIFT      = 1,
    parameter int TIMEOUT    = 1023,
    parameter int AVG_LOG2   = 2
) (
    input  logic                        clk_in,
    input  logic                        reset,
    input  logic                        master_adc,
    input  logic [NUM_SLAVES-1:0]       slave_adc,
    output logic [NUM_SLAVES*CNT_W-1:0] misalign,
    output logic [NUM_SLAVES-1:0]       chan_err,
    output logic                        ready
);
    logic                  m_prev_q, m_r, restart, ready_q, ready_d;
    logic [NUM_SLAVES-1:0] s_prev_q, s_f, done;

    if (NUM_SLAVES < 1 || NUM_SLAVES > 8 || TIMEOUT < 1 || TIMEOUT >= 2**(CNT_W-1) ||
        AVG_LOG2 < 0 || AVG_LOG2 >= CNT_W) begin : g_bad_cfg
        $error("multi_cam_misalign_meter: illegal parameter set");
    end

    // Prev levels track the inputs even in reset so release never fabricates an edge
    always_ff @(posedge clk_in) begin
        m_prev_q <= master_adc;
        s_prev_q <= slave_adc;
    end

    assign m_r     = master_adc & ~m_prev_q;
    assign s_f     = ~slave_adc & s_prev_q;
    assign restart = ready_q & (m_r | (|s_f));
    assign ready_d = ~restart & (&done);

    always_ff @(posedge clk_in) begin
        if (reset) ready_q <= 1'b0;
        else       ready_q <= ready_d;
    end

    assign ready = ready_q;

    for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_chan
        multi_cam_misalign_chan #(
            .CNT_W    (CNT_W),
            .SHIFT    (SHIFT),
            .TIMEOUT  (TIMEOUT)
`ifdef MISALIGN_AVG_EN
            , .AVG_LOG2 (AVG_LOG2)
`endif
        ) u_chan (
            .clk_in    (clk_in),
            .reset     (reset),
            .m_r_i     (m_r),
            .s_f_i     (s_f[g]),
            .restart_i (restart),
            .done_o    (done[g]),
            .err_o     (chan_err[g]),
            .res_o     (misalign[g*CNT_W +: CNT_W])
        );
    end
endmodule

// File: tb/tb_multi_cam_misalign_meter.sv
// Directed bench: table of measurement rounds plus hand sequences for restart, reset and averaging.
module tb_multi_cam_misalign_meter;
    localparam int NS = 3;
    localparam int W  = 16;

    logic            clk_in = 1'b0;
    logic            reset;
    logic            master_adc;
    logic [NS-1:0]   slave_adc;
    logic [NS*W-1:0] misalign;
    logic [NS-1:0]   chan_err;
    logic            ready;

    int n_run  = 0;
    int n_fail = 0;

    typedef struct {
        string         name;
        int            m0;
        int            m1;
        int            s   [NS];
        logic [W-1:0]  mis [NS];
        logic [NS-1:0] err;
    } vec_t;

    vec_t vecs [8];

    always #5 clk_in = ~clk_in;

    multi_cam_misalign_meter #(
        .NUM_SLAVES (NS),
        .CNT_W      (W),
        .SHIFT      (1),
        .TIMEOUT    (1023),
        .AVG_LOG2   (2)
    ) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .master_adc (master_adc),
        .slave_adc  (slave_adc),
        .misalign   (misalign),
        .chan_err   (chan_err),
        .ready      (ready)
    );

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] mis(input int i);
        return misalign[i*W +: W];
    endfunction

    function automatic vec_t mk(input string nm, input int m0, input int m1,
                                input int s0, input int s1, input int s2,
                                input logic [W-1:0] e0, input logic [W-1:0] e1,
                                input logic [W-1:0] e2, input logic [NS-1:0] er);
        vec_t v;
        v.name   = nm;
        v.m0     = m0;
        v.m1     = m1;
        v.s[0]   = s0;
        v.s[1]   = s1;
        v.s[2]   = s2;
        v.mis[0] = e0;
        v.mis[1] = e1;
        v.mis[2] = e2;
        v.err    = er;
        return v;
    endfunction

    // Edges are single-cycle pulses: master high for one cycle, slave low for one cycle
    task automatic run_round(input vec_t v);
        int last;
        int n;
        last = (v.m0 > v.m1) ? v.m0 : v.m1;
        for (int i = 0; i < NS; i++) if (v.s[i] > last) last = v.s[i];
        if (last < 0) last = 0;
        for (int t = 0; t <= last; t++) begin
            master_adc = (t == v.m0) || (t == v.m1);
            for (int i = 0; i < NS; i++) slave_adc[i] = !(t == v.s[i]);
            tick();
        end
        master_adc = 1'b0;
        slave_adc  = '1;
        n = 0;
        while (!ready && n < 1100) begin
            tick();
            n++;
        end
        check({v.name, "_ready"}, 32'(ready), 32'd1);
        for (int i = 0; i < NS; i++)
            check($sformatf("%s_mis%0d", v.name, i), 32'(mis(i)), 32'(v.mis[i]));
        check({v.name, "_err"}, 32'(chan_err), 32'(v.err));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = mk("a_lead_mix",   2, -1, 10,  2,  5, 16'd4,     16'd0,     16'd1,     3'b000);
        vecs[1] = mk("b_slave_lead", 8, -1,  9,  2,  0, 16'd0,     16'hFFFD,  16'hFFFC,  3'b000);
        vecs[2] = mk("c_same",       3, -1,  3,  3,  3, 16'd0,     16'd0,     16'd0,     3'b000);
        vecs[3] = mk("d_pos",        0, -1,  7,  4,  1, 16'd3,     16'd2,     16'd0,     3'b000);
        vecs[4] = mk("e_neg_odd",    5, -1,  0,  1,  5, 16'hFFFE,  16'hFFFE,  16'd0,     3'b000);
        vecs[5] = mk("f_extra_mr",   0,  4,  6,  6,  6, 16'd3,     16'd3,     16'd3,     3'b000);
        vecs[6] = mk("t_tmo_pos",    0, -1, -1,  2,  4, 16'd511,   16'd1,     16'd2,     3'b001);
        vecs[7] = mk("n_tmo_neg",   -1, -1,  0,  0,  0, 16'hFE01,  16'hFE01,  16'hFE01,  3'b111);

        // Inputs sit at "edge" levels through reset; release must not start a round
        master_adc = 1'b1;
        slave_adc  = '0;
        reset      = 1'b1;
        tick();
        tick();
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_err",   32'(chan_err), 32'd0);
        check("rst_mis",   32'(misalign), 32'd0);
        reset = 1'b0;
        repeat (5) tick();
        master_adc = 1'b0;
        slave_adc  = '1;
        repeat (5) tick();
        check("no_spurious_ready", 32'(ready), 32'd0);

`ifdef MISALIGN_AVG_EN
        run_round(mk("avg_first", 0, -1, 16, 16, 16, 16'd8, 16'd8, 16'd8, 3'b000));
        run_round(mk("avg_second", 0, -1, 0, 0, 0, 16'd6, 16'd6, 16'd6, 3'b000));
`else
        for (int k = 0; k < 8; k++) run_round(vecs[k]);

        // Restart from a timed-out round with all edges coincident
        master_adc = 1'b1;
        slave_adc  = '0;
        tick();
        master_adc = 1'b0;
        slave_adc  = '1;
        check("restart_ready_drop", 32'(ready), 32'd0);
        check("restart_err_clear",  32'(chan_err), 32'd0);
        check("restart_mis0_lat1",  32'(mis(0)), 32'd0);
        tick();
        check("restart_ready_back", 32'(ready), 32'd1);

        // Reset in the middle of a round
        run_round(vecs[3]);
        master_adc = 1'b1;
        tick();
        master_adc = 1'b0;
        repeat (3) tick();
        check("midround_ready", 32'(ready), 32'd0);
        check("midround_mis0_held", 32'(mis(0)), 32'd3);
        reset = 1'b1;
        tick();
        check("midrst_ready", 32'(ready), 32'd0);
        check("midrst_mis",   32'(misalign), 32'd0);
        check("midrst_err",   32'(chan_err), 32'd0);
        tick();
        reset = 1'b0;
        repeat (40) tick();
        check("postrst_ready", 32'(ready), 32'd0);
        check("postrst_mis",   32'(misalign), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
